// File: rtl/interp_input_pacer_pkg.sv
// Shared constants for the interpolator input pacer: FSM encoding and default sample width.
package interp_input_pacer_pkg;

   localparam int unsigned DefaultDataWidth = 18;

   typedef logic [1:0] pacerState_t;

   localparam pacerState_t StIdle = 2'd0;
   localparam pacerState_t StFill = 2'd1;
   localparam pacerState_t StRun  = 2'd2;

endpackage

// File: rtl/interp_input_pacer_if.sv
// Upstream valid/ready sample stream into the pacer.
interface interp_input_pacer_if #(
   parameter int unsigned DataWidth = 18
);
   logic [DataWidth-1:0] data;
   logic                 dataValid;
   logic                 ready;

   modport master (output data, output dataValid, input ready);
   modport slave (input data, input dataValid, output ready);
endinterface

// File: rtl/interp_pacer_fifo.sv
// Synchronous FIFO with occupancy count and flush; storage is unreset distributed RAM.
module interp_pacer_fifo
   import interp_input_pacer_pkg::*;
#(
   parameter int unsigned DataWidth = DefaultDataWidth,
   parameter int unsigned DepthLog2 = 4
) (
   input  logic                 Clk_i,
   input  logic                 Rst_i,
   input  logic                 Flush_i,
   input  logic                 Wr_i,
   input  logic [DataWidth-1:0] WrData_i,
   input  logic                 Rd_i,
   output logic [DataWidth-1:0] RdData_o,
   output logic [DepthLog2:0]   Count_o,
   output logic                 Full_o,
   output logic                 Empty_o
);
   localparam int unsigned Depth = 2 ** DepthLog2;
   localparam logic [DepthLog2:0] DepthC = (DepthLog2 + 1)'(Depth);

   logic [DataWidth-1:0] mem [Depth];
   logic [DepthLog2-1:0] wrPtr_q, rdPtr_q;
   logic [DepthLog2:0]   count_q;
   logic                 wrEn, rdEn;

   // Flush wins over both ports so a discarded write never lands.
   assign wrEn = Wr_i & ~Full_o & ~Flush_i;
   assign rdEn = Rd_i & ~Empty_o & ~Flush_i;

   always_ff @(posedge Clk_i or negedge Rst_i) begin
      if (!Rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else if (Flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (wrEn) wrPtr_q <= wrPtr_q + DepthLog2'(1);
         if (rdEn) rdPtr_q <= rdPtr_q + DepthLog2'(1);
         case ({wrEn, rdEn})
            2'b10:   count_q <= count_q + (DepthLog2 + 1)'(1);
            2'b01:   count_q <= count_q - (DepthLog2 + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge Clk_i) begin
      if (wrEn) mem[wrPtr_q] <= WrData_i;
   end

   assign RdData_o = mem[rdPtr_q];
   assign Count_o  = count_q;
   assign Full_o   = (count_q == DepthC);
   assign Empty_o  = (count_q == '0);

endmodule

// File: rtl/interp_input_pacer.sv
// Buffers bursty upstream samples and re-issues them as new-data strobes on a fixed
// Period-cycle cadence, flagging slots that find the FIFO empty.
module interp_input_pacer
   import interp_input_pacer_pkg::*;
#(
   parameter int unsigned DataWidth     = DefaultDataWidth,
   parameter int unsigned FifoDepthLog2 = 4,
   parameter int unsigned Period        = 16,
   parameter int unsigned StartLevel    = 4
) (
   input  logic                     Clk_i,
   input  logic                     Rst_i,
   input  logic                     Enable_i,
   interp_input_pacer_if.slave      Up,
   output logic [DataWidth-1:0]     Data_o,
   output logic                     DataNd_o,
   output logic [FifoDepthLog2:0]   Level_o,
   output logic                     Underrun_o
);
   localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
   localparam logic [CntW-1:0] Reload = CntW'(Period - 1);
   localparam logic [FifoDepthLog2:0] StartLvl = (FifoDepthLog2 + 1)'(StartLevel);

   pacerState_t          state_q, state_d;
   logic [CntW-1:0]      slotCnt_q, slotCnt_d;
   logic [DataWidth-1:0] fifoHead;
   logic [FifoDepthLog2:0] fifoCount;
   logic                 fifoFull, fifoEmpty;
   logic                 fifoWr, fifoRd, fifoFlush, slotHit;

   assign slotHit   = (state_q == StRun) & (slotCnt_q == '0);
   assign Up.ready  = (state_q != StIdle) & ~fifoFull;
   assign fifoWr    = Up.dataValid & Up.ready & Enable_i;
   assign fifoRd    = slotHit & Enable_i & ~fifoEmpty;
   assign fifoFlush = ~Enable_i | (state_q == StIdle);
   assign Level_o   = fifoCount;

   interp_pacer_fifo #(
      .DataWidth(DataWidth),
      .DepthLog2(FifoDepthLog2)
   ) u_fifo (
      .Clk_i   (Clk_i),
      .Rst_i   (Rst_i),
      .Flush_i (fifoFlush),
      .Wr_i    (fifoWr),
      .WrData_i(Up.data),
      .Rd_i    (fifoRd),
      .RdData_o(fifoHead),
      .Count_o (fifoCount),
      .Full_o  (fifoFull),
      .Empty_o (fifoEmpty)
   );

   always_comb begin
      state_d   = state_q;
      slotCnt_d = slotCnt_q;
      if (!Enable_i) begin
         state_d   = StIdle;
         slotCnt_d = '0;
      end else begin
         case (state_q)
            StIdle: state_d = StFill;
            StFill: begin
               // Entering RUN with the counter at 0 makes the very next edge a slot.
               if (fifoCount >= StartLvl) begin
                  state_d   = StRun;
                  slotCnt_d = '0;
               end
            end
            StRun:   slotCnt_d = (slotCnt_q == '0) ? Reload : slotCnt_q - CntW'(1);
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge Clk_i or negedge Rst_i) begin
      if (!Rst_i) begin
         state_q    <= StIdle;
         slotCnt_q  <= '0;
         Data_o     <= '0;
         DataNd_o   <= 1'b0;
         Underrun_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         slotCnt_q  <= slotCnt_d;
         DataNd_o   <= fifoRd;
         Underrun_o <= slotHit & Enable_i & fifoEmpty;
         if (fifoRd) Data_o <= fifoHead;
      end
   end

endmodule

// File: tb/tb_interp_input_pacer.sv
// Self-checking bench for interp_input_pacer: queue-based model checked every cycle,
// plus hand-computed timing and data expectations for directed scenarios.
module tb_interp_input_pacer;
   localparam int unsigned DW = 18;
   localparam int unsigned DL = 4;
   localparam int unsigned Depth = 16;
   localparam int unsigned Period = 16;
   localparam int unsigned StartLevel = 4;

   logic          Clk, Rst, Enable;
   logic [DW-1:0] DataOut;
   logic          DataNd, Underrun;
   logic [DL:0]   Level;

   interp_input_pacer_if #(.DataWidth(DW)) up ();

   interp_input_pacer #(
      .DataWidth    (DW),
      .FifoDepthLog2(DL),
      .Period       (Period),
      .StartLevel   (StartLevel)
   ) dut (
      .Clk_i     (Clk),
      .Rst_i     (Rst),
      .Enable_i  (Enable),
      .Up        (up.slave),
      .Data_o    (DataOut),
      .DataNd_o  (DataNd),
      .Level_o   (Level),
      .Underrun_o(Underrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Model: mode 0/1/2 = idle/fill/run; slots fall at absolute edge numbers.
   int            cyc = 0;
   int            mMode = 0;
   logic [DW-1:0] mQ[$];
   int            mNextSlot = 0;
   logic [DW-1:0] eData = '0;
   bit            eNd = 0, eUnder = 0, mAccLast = 0;

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         mMode = 0;
         mQ.delete();
         eData = '0;
         eNd = 0;
         eUnder = 0;
         mAccLast = 0;
      end else begin
         bit rdy, acc;
         cyc++;
         rdy = (mMode != 0) && (mQ.size() < Depth);
         acc = up.dataValid && rdy && Enable;
         eNd = 0;
         eUnder = 0;
         mAccLast = 0;
         if (!Enable) begin
            mMode = 0;
            mQ.delete();
         end else begin
            if (mMode == 0) mMode = 1;
            else if (mMode == 1) begin
               if (mQ.size() >= StartLevel) begin
                  mMode = 2;
                  mNextSlot = cyc + 1;
               end
            end else if (cyc == mNextSlot) begin
               mNextSlot += Period;
               if (mQ.size() > 0) begin
                  eData = mQ.pop_front();
                  eNd = 1;
               end else eUnder = 1;
            end
            if (acc) begin
               mQ.push_back(up.data);
               mAccLast = 1;
            end
         end
      end
   end

   int nCmp = 0, nErr = 0;
   bit chkEn = 0;
   int ndCyc[$];
   int urCyc[$];
   logic [DW-1:0] ndData[$];
   int maxLevel = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s at edge %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      nCmp++;
      nErr++;
      $display("FAIL %s at edge %0d: bounded wait expired", name, cyc);
   endtask

   always begin
      @(posedge Clk);
      #1;
      if (chkEn && Rst) begin
         check("ready", up.ready, (mMode != 0) && (mQ.size() < Depth));
         check("level", Level, mQ.size());
         check("data", DataOut, eData);
         check("nd", DataNd, eNd);
         check("underrun", Underrun, eUnder);
         if (DataNd) begin
            ndCyc.push_back(cyc);
            ndData.push_back(DataOut);
         end
         if (Underrun) urCyc.push_back(cyc);
         if (int'(Level) > maxLevel) maxLevel = int'(Level);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #3;
      end
   endtask

   task automatic clearLogs();
      ndCyc.delete();
      ndData.delete();
      urCyc.delete();
   endtask

   task automatic sendWord(input logic [DW-1:0] v);
      up.data = v;
      up.dataValid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (mAccLast) begin
            up.dataValid = 1'b0;
            return;
         end
      end
      up.dataValid = 1'b0;
      failNow("send_timeout");
   endtask

   int enEdge, t4;

   initial begin
      Rst = 1'b0;
      Enable = 1'b0;
      up.dataValid = 1'b0;
      up.data = '0;
      repeat (3) @(posedge Clk);
      #3;
      check("rst_data", DataOut, 0);
      check("rst_nd", DataNd, 0);
      check("rst_underrun", Underrun, 0);
      check("rst_level", Level, 0);
      check("rst_ready", up.ready, 0);
      Rst = 1'b1;
      chkEn = 1'b1;
      step(2);

      // Fill with 1..4, drain, underrun, then a late sample waits for the slot boundary.
      clearLogs();
      Enable = 1'b1;
      enEdge = cyc + 1;
      for (int i = 1; i <= 4; i++) sendWord(DW'(i));
      step(90);
      sendWord(DW'(7));
      step(10);
      check("t2_nd_count", ndCyc.size(), 5);
      check("t4_ur_count", urCyc.size(), 2);
      if (ndCyc.size() == 5) begin
         for (int i = 0; i < 4; i++) begin
            check("t2_nd_time", ndCyc[i], enEdge + 6 + 16 * i);
            check("t2_nd_data", ndData[i], i + 1);
         end
         check("t4_late_time", ndCyc[4], enEdge + 102);
         check("t4_late_data", ndData[4], 7);
      end
      if (urCyc.size() == 2) begin
         check("t4_ur_time0", urCyc[0], enEdge + 70);
         check("t4_ur_time1", urCyc[1], enEdge + 86);
      end

      // Continuous stream: back-pressure at full, order preserved, strict spacing.
      clearLogs();
      maxLevel = 0;
      for (int i = 0; i < 40; i++) sendWord(DW'(i));
      step(700);
      check("t3_count", ndData.size(), 40);
      check("t3_max_level", maxLevel, 16);
      if (ndData.size() == 40) begin
         for (int i = 0; i < 40; i++) check("t3_order", ndData[i], i);
         for (int i = 0; i < 39; i++) check("t3_spacing", ndCyc[i + 1] - ndCyc[i], 16);
      end

      // Disable in RUN with five queued words, then re-enable and refill.
      for (int i = 0; i < 40 && (mNextSlot - cyc) != int'(Period); i++) step(1);
      if ((mNextSlot - cyc) != int'(Period)) failNow("t5_align");
      for (int i = 0; i < 5; i++) sendWord(DW'('h50 + i));
      check("t5_level5", Level, 5);
      clearLogs();
      Enable = 1'b0;
      step(1);
      check("t5_level0", Level, 0);
      check("t5_ready0", up.ready, 0);
      step(40);
      check("t5_no_nd", ndCyc.size(), 0);
      check("t5_no_ur", urCyc.size(), 0);
      Enable = 1'b1;
      for (int i = 0; i < 3; i++) sendWord(DW'('h100 + i));
      step(30);
      check("t5_fill_hold", ndCyc.size(), 0);
      sendWord(DW'('h103));
      t4 = cyc;
      step(2);
      check("t5_first_nd", DataNd, 1);
      check("t5_first_data", DataOut, 'h100);

      // Write on the same edge a slot pops, with three words queued.
      for (int i = 0; i < 40 && cyc < t4 + 17; i++) step(1);
      check("t6_level_pre", Level, 3);
      sendWord(DW'('h1AA));
      check("t6_edge", cyc, t4 + 18);
      check("t6_level", Level, 3);
      check("t6_nd", DataNd, 1);
      check("t6_head", DataOut, 'h101);
      step(60);
      check("t6_count", ndData.size(), 5);
      if (ndData.size() == 5) begin
         check("t6_seq2", ndData[2], 'h102);
         check("t6_seq3", ndData[3], 'h103);
         check("t6_seq4", ndData[4], 'h1AA);
      end

      // Asynchronous reset right after a strobe clears everything before the next edge.
      sendWord(DW'('h2A));
      sendWord(DW'('h2B));
      for (int i = 0; i < 40 && !eNd; i++) step(1);
      if (!eNd) failNow("t1_wait_nd");
      Rst = 1'b0;
      #1;
      check("t1_async_data", DataOut, 0);
      check("t1_async_nd", DataNd, 0);
      check("t1_async_underrun", Underrun, 0);
      check("t1_async_level", Level, 0);
      check("t1_async_ready", up.ready, 0);
      step(2);
      Rst = 1'b1;
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
